load_store_unit: RTL and testbench

- Multi-cycle load/store unit for the RV32I core. Sits directly upstream of the register file write port.
- Takes the rs1/rs2 read data plus the decoded immediate, runs one data-memory transaction over a req/ack handshake, and aligns and sign-extends load data.
- Drives the register file's write, rd and writedata inputs.

---
 rtl/lsu_pkg.sv | 16 +
 rtl/load_align.sv | 18 +
 rtl/load_store_unit.sv | 112 +++++++++++
 tb/tb_load_store_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, funct3 codes and request legality helpers for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_t;
  typedef enum logic [1:0] {FC_NONE, FC_MISALIGN, FC_ILLEGAL, FC_TIMEOUT} fault_cause_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic f3_illegal(input logic st, input logic [2:0] f3);
    return st ? (f3[2] || f3[1:0] == 2'b11) : (f3[1:0] == 2'b11 || f3[2:1] == 2'b11);
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return f3[1] ? |lo : f3[0] & lo[0];
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/halfword lane of a read word and extends it
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  ea_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = 8'(rdata >> {ea_lo, 3'b000});
  assign h = ea_lo[1] ? rdata[31:16] : rdata[15:0];
  assign result = funct3 == F3_B  ? {{24{b[7]}}, b} :
                  funct3 == F3_BU ? {24'h0, b} :
                  funct3 == F3_H  ? {{16{h[15]}}, h} :
                  funct3 == F3_HU ? {16'h0, h} : rdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one data-memory transaction per start over req/ack, feeding the register file write port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rf_write,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_writedata
);
  lsu_state_t   state, state_nx;
  fault_cause_t cause_q;
  logic [15:0]  cnt;
  logic [31:0]  ea, ld_res, wd;
  logic [3:0]   be;
  logic [2:0]   f3_q;
  logic [1:0]   lo_q;
  logic [4:0]   rd_q;
  logic         st_q, bad, timeout;
  assign ea = base + offset;
  assign bad = f3_illegal(is_store, funct3) || misaligned(funct3, ea[1:0]);
  assign timeout = cnt == 16'(TIMEOUT_CYCLES - 1);
  assign be = funct3[1] ? 4'hF : funct3[0] ? (ea[1] ? 4'hC : 4'h3) : 4'b0001 << ea[1:0];
  assign wd = funct3[1] ? store_data : funct3[0] ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
  assign busy = state != IDLE;
  assign fault_cause = cause_q;
  load_align u_align (.rdata(mem_rdata), .ea_lo(lo_q), .funct3(f3_q), .result(ld_res));
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? (bad ? RESP : REQ) : IDLE) :
               state == REQ  ? (mem_ack || timeout ? RESP : REQ) : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      done <= 1'b0;
      fault <= 1'b0;
      cause_q <= FC_NONE;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
      rf_write <= 1'b0;
      rf_rd <= '0;
      rf_writedata <= '0;
      f3_q <= '0;
      lo_q <= '0;
      rd_q <= '0;
      st_q <= 1'b0;
    end else begin
      done <= 1'b0;
      fault <= 1'b0;
      cause_q <= FC_NONE;
      rf_write <= 1'b0;
      case (state)
        IDLE: if (start && bad) begin
          done <= 1'b1;
          fault <= 1'b1;
          cause_q <= f3_illegal(is_store, funct3) ? FC_ILLEGAL : FC_MISALIGN;
        end else if (start) begin
          mem_req <= 1'b1;
          mem_we <= is_store;
          mem_addr <= {ea[31:2], 2'b00};
          mem_be <= be;
          mem_wdata <= wd;
          rd_q <= rd_in;
          f3_q <= funct3;
          lo_q <= ea[1:0];
          st_q <= is_store;
        end
        REQ: if (mem_ack || timeout) begin
          mem_req <= 1'b0;
          cnt <= '0;
          done <= 1'b1;
          fault <= !mem_ack;
          cause_q <= mem_ack ? FC_NONE : FC_TIMEOUT;
          // x0 is never written, and rf_rd/rf_writedata keep their last real write
          if (mem_ack && !st_q && rd_q != 5'd0) begin
            rf_write <= 1'b1;
            rf_rd <= rd_q;
            rf_writedata <= ld_res;
          end
        end else cnt <= cnt + 16'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with a completion scoreboard and a memory-request monitor
module tb_load_store_unit;
  localparam int TO = 4;
  logic clk = 0, reset_n = 0, start = 0, is_store = 0, mem_ack = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] base = 0, offset = 0, store_data = 0, mem_rdata = 0;
  logic [4:0] rd_in = 0;
  logic busy, done, fault, mem_req, mem_we, rf_write;
  logic [1:0] fault_cause;
  logic [31:0] mem_addr, mem_wdata, rf_writedata;
  logic [3:0] mem_be;
  logic [4:0] rf_rd;
  typedef struct {logic fault; logic [1:0] cause; logic wr; logic [4:0] rd; logic [31:0] data; int lat; int t0;} exp_t;
  typedef struct {logic v; logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} mem_t;
  exp_t sb[$];
  mem_t cur;
  int cyc = 0, checks = 0, errors = 0, req_cycles = 0, dones = 0, pushes = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_store(is_store), .funct3(funct3),
    .base(base), .offset(offset), .store_data(store_data), .rd_in(rd_in), .busy(busy),
    .done(done), .fault(fault), .fault_cause(fault_cause), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .rf_write(rf_write), .rf_rd(rf_rd), .rf_writedata(rf_writedata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, x, cyc);
    end
  endtask

  function automatic exp_t ex(input logic f, input logic [1:0] c, input logic w, input logic [4:0] r,
                              input logic [31:0] d, input int l);
    ex.fault = f; ex.cause = c; ex.wr = w; ex.rd = r; ex.data = d; ex.lat = l; ex.t0 = 0;
  endfunction

  function automatic mem_t mm(input logic v, input logic we, input logic [31:0] a, input logic [3:0] b,
                              input logic [31:0] wd);
    mm.v = v; mm.we = we; mm.addr = a; mm.be = b; mm.wdata = wd;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (mem_req) begin
          req_cycles++;
          if (!cur.v) chk("unexpected_req", 1, 0);
          else begin
            chk("mem_we", mem_we, cur.we);
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_be", mem_be, cur.be);
            chk("mem_wdata", mem_wdata, cur.wdata);
          end
        end
        if (done) begin
          dones++;
          if (sb.size() == 0) chk("spurious_done", 1, 0);
          else begin
            e = sb.pop_front();
            chk("fault", fault, e.fault);
            chk("fault_cause", fault_cause, e.cause);
            chk("rf_write", rf_write, e.wr);
            chk("latency", cyc - e.t0, e.lat);
            if (e.wr) begin
              chk("rf_rd", rf_rd, e.rd);
              chk("rf_writedata", rf_writedata, e.data);
            end
          end
        end else chk("idle_flags", {rf_write, fault, fault_cause}, 0);
      end
    end
  end

  task automatic op(input logic st, input logic [2:0] f3, input logic [31:0] b, input logic [31:0] o,
                    input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] rdata, input int wn,
                    input bit ack, input bit hold, input exp_t e, input mem_t m, input int exp_req);
    @(negedge clk);
    is_store = st; funct3 = f3; base = b; offset = o; store_data = sd; rd_in = rd; start = 1;
    e.t0 = cyc; sb.push_back(e); pushes++; cur = m; req_cycles = 0;
    @(posedge clk); #1 start = hold;
    if (m.v) begin
      if (ack) begin
        repeat (wn) @(posedge clk);
        @(negedge clk); mem_ack = 1; mem_rdata = rdata;
        @(posedge clk); #1 mem_ack = 0;
      end else begin
        repeat (TO) @(posedge clk); #1;
      end
      cur.v = 0;
    end
    if (hold) begin @(posedge clk); #1 start = 0; end
    for (int i = 0; i < 20 && busy; i++) @(posedge clk);
    @(negedge clk);
    chk("return_idle", busy, 0);
    chk("req_cycles", req_cycles, exp_req);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cur = mm(0, 0, 0, 0, 0);
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_rf", {rf_write, rf_rd}, 0); chk("rst_rf_data", rf_writedata, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    // loads
    op(0, 3'b010, 32'h1000, 32'd4, 0, 5'd5, 32'hDEADBEEF, 0, 1, 0, ex(0, 0, 1, 5, 32'hDEADBEEF, 2), mm(1, 0, 32'h1004, 4'hF, 0), 1);
    op(0, 3'b000, 32'h1000, 32'd3, 0, 5'd6, 32'h80FF1234, 0, 1, 0, ex(0, 0, 1, 6, 32'hFFFFFF80, 2), mm(1, 0, 32'h1000, 4'h8, 0), 1);
    op(0, 3'b100, 32'h1000, 32'd3, 0, 5'd7, 32'h80FF1234, 0, 1, 0, ex(0, 0, 1, 7, 32'h00000080, 2), mm(1, 0, 32'h1000, 4'h8, 0), 1);
    op(0, 3'b001, 32'h1000, 32'd2, 0, 5'd8, 32'h80FF1234, 1, 1, 0, ex(0, 0, 1, 8, 32'hFFFF80FF, 3), mm(1, 0, 32'h1000, 4'hC, 0), 2);
    op(0, 3'b101, 32'h1000, 32'd0, 0, 5'd10, 32'h80FF1234, 0, 1, 0, ex(0, 0, 1, 10, 32'h00001234, 2), mm(1, 0, 32'h1000, 4'h3, 0), 1);
    // stores
    op(1, 3'b001, 32'h2000, 32'd2, 32'h0000ABCD, 5'd0, 0, 3, 1, 0, ex(0, 0, 0, 0, 0, 5), mm(1, 1, 32'h2000, 4'hC, 32'hABCDABCD), 4);
    op(1, 3'b000, 32'h2000, 32'd1, 32'h123456EF, 5'd0, 0, 1, 1, 0, ex(0, 0, 0, 0, 0, 3), mm(1, 1, 32'h2000, 4'h2, 32'hEFEFEFEF), 2);
    op(1, 3'b010, 32'h2008, 32'hFFFFFFFC, 32'hCAFEF00D, 5'd0, 0, 0, 1, 0, ex(0, 0, 0, 0, 0, 2), mm(1, 1, 32'h2004, 4'hF, 32'hCAFEF00D), 1);
    // faults without memory access
    op(0, 3'b010, 32'h1000, 32'd1, 0, 5'd5, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 1), mm(0, 0, 0, 0, 0), 0);
    op(0, 3'b001, 32'h1000, 32'd3, 0, 5'd5, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 1), mm(0, 0, 0, 0, 0), 0);
    op(0, 3'b011, 32'h1001, 32'd0, 0, 5'd5, 0, 0, 0, 0, ex(1, 2, 0, 0, 0, 1), mm(0, 0, 0, 0, 0), 0);
    op(1, 3'b100, 32'h2000, 32'd0, 0, 5'd0, 0, 0, 0, 0, ex(1, 2, 0, 0, 0, 1), mm(0, 0, 0, 0, 0), 0);
    // timeout, then a stray ack while idle
    op(0, 3'b010, 32'h3000, 32'd0, 0, 5'd4, 0, 0, 0, 0, ex(1, 3, 0, 0, 0, 5), mm(1, 0, 32'h3000, 4'hF, 0), 4);
    @(negedge clk); mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1 mem_ack = 0;
    repeat (2) @(negedge clk);
    chk("late_ack_idle", {busy, mem_req}, 0);
    // rd=0 load completes without writing; last write stays visible
    op(0, 3'b010, 32'h1000, 32'd8, 0, 5'd0, 32'h12345678, 0, 1, 0, ex(0, 0, 0, 0, 0, 2), mm(1, 0, 32'h1008, 4'hF, 0), 1);
    chk("hold_rf_rd", rf_rd, 10);
    chk("hold_rf_data", rf_writedata, 32'h00001234);
    // start held high through REQ and RESP
    op(0, 3'b010, 32'h1000, 32'hC, 0, 5'd9, 32'h11223344, 0, 1, 1, ex(0, 0, 1, 9, 32'h11223344, 2), mm(1, 0, 32'h100C, 4'hF, 0), 1);
    // reset in the middle of REQ
    @(negedge clk);
    is_store = 0; funct3 = 3'b010; base = 32'h4000; offset = 0; rd_in = 5'd3; start = 1;
    cur = mm(1, 0, 32'h4000, 4'hF, 0);
    @(posedge clk); @(posedge clk); #2 reset_n = 0;
    #1;
    chk("arst_busy", busy, 0); chk("arst_mem_req", mem_req, 0); chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_be", mem_be, 0); chk("arst_mem_wdata", mem_wdata, 0); chk("arst_done", {done, fault, fault_cause}, 0);
    chk("arst_rf", {rf_write, rf_rd}, 0); chk("arst_rf_data", rf_writedata, 0);
    start = 0; cur.v = 0;
    @(negedge clk); reset_n = 1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", {busy, mem_req}, 0);
    chk("sb_empty", sb.size(), 0);
    chk("done_count", dones, pushes);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
